// File: rtl/dm_store_buffer_pkg.sv
// dm_store_buffer_pkg
// Store opcode encodings and helpers shared by the store buffer and its
// alignment sub-module. The `*_ST macros sit beside the load-side *_EXT codes
// and carry the same values as the localparams below.
// Configuration macro used by the design: STORE_ALIGN_EXC_EN.

`ifndef NONE_ST
`define NONE_ST 3'd0
`endif
`ifndef SB_ST
`define SB_ST 3'd1
`endif
`ifndef SH_ST
`define SH_ST 3'd2
`endif
`ifndef SW_ST
`define SW_ST 3'd3
`endif

package dm_store_buffer_pkg;

  localparam logic [2:0] NONE_ST_OP = `NONE_ST;
  localparam logic [2:0] SB_ST_OP   = `SB_ST;
  localparam logic [2:0] SH_ST_OP   = `SH_ST;
  localparam logic [2:0] SW_ST_OP   = `SW_ST;

  function automatic logic is_store_op(input logic [2:0] op);
    return (op == SB_ST_OP) || (op == SH_ST_OP) || (op == SW_ST_OP);
  endfunction

endpackage

// File: rtl/dm_store_buffer_store_align.sv
// store_align
// Combinational byte-lane alignment of a store request.
// Ports:
//   op       in   store opcode (SB/SH/SW; anything else gives zero enables)
//   addr_lo  in   byte offset within the word
//   wdata    in   raw register data, value in the low bits
//   byteen   out  byte enables for the addressed lanes
//   wdata_al out  data replicated across lanes
// Misaligned halfwords/words are force-aligned here: SH looks at addr_lo[1]
// only and SW ignores addr_lo altogether. Trapping them is done by the parent
// when STORE_ALIGN_EXC_EN is defined.

import dm_store_buffer_pkg::*;

module store_align (
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_al
);

  always_comb begin
    byteen   = 4'b0000;
    wdata_al = 32'h0;
    case (op)
      SB_ST_OP: begin
        byteen   = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
      end
      SH_ST_OP: begin
        byteen   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata[15:0]}};
      end
      SW_ST_OP: begin
        byteen   = 4'b1111;
        wdata_al = wdata;
      end
      default: begin
        byteen   = 4'b0000;
        wdata_al = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer
// Aligns SB/SH/SW stores from the MEM stage, queues them in a small FIFO and
// drains them to the data-memory bridge over a req/ack handshake.
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   st_valid/st_op/st_addr/st_wdata  store request from MEM
//   st_ready         buffer has room (registered count only)
//   st_exc           misaligned store flag (0 unless STORE_ALIGN_EXC_EN)
//   buf_empty/buf_count  occupancy; loads wait for buf_empty
//   bus_req/bus_addr/bus_byteen/bus_wdata  head entry presented to the bus
//   bus_ack          bus has written the head entry
// Configuration macro: STORE_ALIGN_EXC_EN (trap misaligned SH/SW instead of
// force-aligning them).

import dm_store_buffer_pkg::*;

module dm_store_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [2:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  output logic             st_ready,
  output logic             st_exc,
  output logic             buf_empty,
  output logic [PTR_W:0]   buf_count,
  output logic             bus_req,
  output logic [31:0]      bus_addr,
  output logic [3:0]       bus_byteen,
  output logic [31:0]      bus_wdata,
  input  logic             bus_ack
);

  logic [29:0]      q_addr [DEPTH];
  logic [3:0]       q_be   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic [3:0]  al_be;
  logic [31:0] al_data;
  logic        push, pop;

  store_align u_align (
    .op       (st_op),
    .addr_lo  (st_addr[1:0]),
    .wdata    (st_wdata),
    .byteen   (al_be),
    .wdata_al (al_data)
  );

`ifdef STORE_ALIGN_EXC_EN
  assign st_exc = st_valid && (((st_op == SH_ST_OP) && st_addr[0]) ||
                               ((st_op == SW_ST_OP) && (st_addr[1:0] != 2'b00)));
`else
  assign st_exc = 1'b0;
`endif

  // No pop-to-push bypass: a full buffer refuses even while popping.
  assign st_ready  = (count != (PTR_W+1)'(DEPTH));
  assign buf_empty = (count == '0);
  assign buf_count = count;
  assign bus_req   = !buf_empty;

  assign push = st_valid && st_ready && is_store_op(st_op) && !st_exc;
  assign pop  = bus_req && bus_ack;

  assign bus_addr   = {q_addr[head], 2'b00};
  assign bus_byteen = q_be[head];
  assign bus_wdata  = q_data[head];

  // Entries are cleared on reset so the idle bus fields read back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_be[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_addr[tail] <= st_addr[31:2];
        q_be[tail]   <= al_be;
        q_data[tail] <= al_data;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Store-side counterpart of the load-data extender: turns SB/SH/SW requests from the MEM stage into byte-lane-aligned write data plus byte enables.
- Queues aligned stores in a small FIFO write buffer.
- Drains the buffer to the data-memory/bridge bus over a req/ack handshake.
- Sits between the MEM stage and the system bridge; the pipeline stalls on buffer-full, and loads stall until the buffer is empty.

Parameters:
- DEPTH, 2, number of buffered store entries; power of two, at least 2.
- PTR_W, 1, pointer width, equal to log2(DEPTH); count registers are PTR_W+1 bits wide.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- st_valid  input  1  MEM stage presents a store this cycle.
- st_op  input  3  store type: `NONE_ST / `SB_ST / `SH_ST / `SW_ST.
- st_addr  input  32  byte address of the store.
- st_wdata  input  32  raw register data (value in low bits).
- st_ready  output  1  buffer can accept; a store is taken only when st_valid && st_ready.
- st_exc  output  1  combinational misaligned-store flag (see Optional Feature).
- buf_empty  output  1  no pending stores; loads issue only when this is 1.
- buf_count  output  PTR_W+1  number of pending entries.
- bus_req  output  1  head entry valid on the bus.
- bus_addr  output  32  word-aligned address {st_addr[31:2], 2'b00} of the head entry.
- bus_byteen  output  4  byte enables of the head entry.
- bus_wdata  output  32  lane-aligned data of the head entry.
- bus_ack  input  1  bus has written the head entry this cycle.

Behaviour:
- Alignment is combinational, before the push.
  - SB: byteen = 4'b0001 << addr[1:0]; wdata = {4{st_wdata[7:0]}}.
  - SH: byteen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st_wdata[15:0]}}.
  - SW: byteen = 4'b1111; wdata = st_wdata.
  - `NONE_ST or an undefined code is never pushed.
- Push: st_valid && st_ready && legal op && !st_exc. The entry is written at the tail and the tail pointer increments, wrapping modulo DEPTH.
- Pop: bus_req && bus_ack. The head pointer increments, wrapping.
- st_ready = (count != DEPTH), derived from registered count only. There is no same-cycle pop-to-push bypass, so a full buffer refuses a push even while a pop occurs.
- Push and pop in the same cycle with 0 < count < DEPTH leaves count unchanged; both pointers advance.
- Latency: a push into an empty buffer appears on bus_req and the bus fields in the next cycle. bus_* fields are driven from the head entry register.
- Ordering is strict FIFO; entries are never merged or reordered.
- bus_req = !buf_empty. bus_addr, bus_byteen and bus_wdata must stay stable while bus_req is high and bus_ack is low.
- bus_ack while bus_req = 0 is ignored.
- Reset values (asynchronous):
  - head, tail and count all 0.
  - bus_req 0, bus_addr 0, bus_byteen 0, bus_wdata 0.
  - st_ready 1, buf_empty 1, buf_count 0.
- Reset mid-transaction drops all pending stores. No bus_req is asserted until a new push.

Optional Feature:
- Macro STORE_ALIGN_EXC_EN.
- Defined:
  - st_exc = st_valid && ((SH && addr[0]) || (SW && addr[1:0] != 0)).
  - A flagged store is not pushed, and st_ready is unaffected.
- Undefined:
  - st_exc is tied to 0.
  - Misaligned stores are force-aligned: SH uses addr[1] only; SW ignores addr[1:0].

Decomposition:
- Store op codes `NONE_ST, `SB_ST, `SH_ST and `SW_ST go in the shared defines.v, beside the existing *_EXT load codes.
- One combinational sub-module, store_align, maps (st_op, addr[1:0], st_wdata) to (byteen, aligned wdata).
- The FIFO and handshake logic stay in dm_store_buffer.

Test Plan:
- Reset, then SB at addr 0x13, data 0x000000A5 -> next cycle bus_req=1, bus_addr=0x10, byteen=4'b1000, wdata=0xA5A5A5A5.
- SH at 0x22, data 0x1234BEEF -> byteen=4'b1100, wdata=0xBEEFBEEF. SW at 0x40 -> byteen=4'b1111.
- Fill: push 2 stores with bus_ack=0 -> st_ready=0, buf_count=2. A third st_valid is not accepted. After one bus_ack, the next cycle has st_ready=1 and the second entry is at the head.
- Simultaneous push and pop at count=1 -> count stays 1 and ordering is preserved across pointer wrap for 6 consecutive stores.
- Assert reset with 2 pending and bus_req=1 -> bus_req=0 and buf_empty=1 immediately, without waiting for a clock edge.
- With STORE_ALIGN_EXC_EN, SW at 0x41 -> st_exc=1 and count unchanged. Without it -> pushed, bus_addr=0x40.
